// File: rtl/booth_pkg.sv
// booth_pkg: definitions shared by the Booth multiplier dispatcher and its benches.
//   MODE_*      : sign-mode encodings (bit1 = multiplicand signed, bit0 = multiplier signed)
//   MUL_W       : operand width assumed by the reference model
//   ref_product : reference product with the sign handling of booth_radix8_multiplier
`timescale 1ns/1ps
package booth_pkg;

    localparam logic [1:0] MODE_UU = 2'b00;
    localparam logic [1:0] MODE_US = 2'b01;
    localparam logic [1:0] MODE_SU = 2'b10;
    localparam logic [1:0] MODE_SS = 2'b11;

    localparam int MUL_W = 16;

    // Both operands are extended to the product width according to their sign
    // flag. The low 2*MUL_W bits of that product are the exact signed, unsigned
    // or mixed-sign result.
    function automatic logic [2*MUL_W-1:0] ref_product(
        input logic [MUL_W-1:0] a,
        input logic [MUL_W-1:0] b,
        input logic [1:0]       mode
    );
        logic [2*MUL_W-1:0] ea;
        logic [2*MUL_W-1:0] eb;
        ea = mode[1] ? {{MUL_W{a[MUL_W-1]}}, a} : {{MUL_W{1'b0}}, a};
        eb = mode[0] ? {{MUL_W{b[MUL_W-1]}}, b} : {{MUL_W{1'b0}}, b};
        return ea * eb;
    endfunction

endpackage

// File: rtl/booth_mul_dispatcher_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with a synchronous active-low reset.
//   clk, rst_n       : clock and reset
//   push, wr_data    : write request and data (ignored when full unless popping too)
//   pop              : consume the head entry (ignored when empty)
//   rd_data          : head entry, valid whenever empty is low
//   full, empty      : occupancy flags
//   count            : number of stored entries (0..DEPTH)
`timescale 1ns/1ps
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DW-1:0]          wr_data,
    input  logic                   pop,
    output logic [DW-1:0]          rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign empty   = (r_count == '0);
    assign full    = (r_count == FULL_CNT);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted only when the head is leaving in the
    // same cycle; the write then lands in the slot the head just vacated.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full && !pop))
                else $error("sync_fifo: push while full without pop");
        end
    end

endmodule

// File: rtl/booth_mul_dispatcher.sv
// booth_mul_dispatcher: issues tagged multiply requests to a non-stallable
// multiplier (start/busy/done) and returns products in acceptance order.
//   clk, rst_n                     : clock, synchronous active-low reset
//   in_valid/in_ready, in_a, in_b,
//   in_mode, in_tag                : request channel
//   out_valid/out_ready,
//   out_product, out_tag           : result channel with full backpressure
//   mul_start, mul_multiplicand,
//   mul_multiplier, mul_sign_mode  : multiplier command side
//   mul_product, mul_done, mul_busy: multiplier response side
//   inflight                       : tags issued but not yet completed
//   err_orphan                     : sticky flag, done seen with nothing outstanding
`timescale 1ns/1ps
module booth_mul_dispatcher
    import booth_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [1:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_product,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_multiplicand,
    output logic [WIDTH-1:0]         mul_multiplier,
    output logic [1:0]               mul_sign_mode,
    input  logic [2*WIDTH-1:0]       mul_product,
    input  logic                     mul_done,
    input  logic                     mul_busy,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     err_orphan
);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int RDW  = 2*WIDTH + TAG_W;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    logic [CW-1:0]    w_tag_count;
    logic [CW-1:0]    w_res_count;
    logic [CW:0]      w_outstanding;
    logic             w_tag_empty;
    logic             w_tag_full;
    logic             w_res_empty;
    logic             w_res_full;
    logic [TAG_W-1:0] w_tag_head;
    logic [RDW-1:0]   w_res_head;
    logic             w_tag_push;
    logic             w_tag_pop;
    logic             w_res_push;
    logic             w_res_pop;
    logic             r_err_orphan;

    // Every issued op will eventually need a result slot, so tags in flight and
    // buffered results share one credit pool. This is what keeps the result
    // FIFO from overflowing when the multiplier cannot be stalled.
    assign w_outstanding = {1'b0, w_tag_count} + {1'b0, w_res_count};
    assign in_ready      = rst_n && !mul_busy && (w_outstanding < CREDITS);

    assign mul_start        = in_valid && in_ready;
    assign mul_multiplicand = in_a;
    assign mul_multiplier   = in_b;
    assign mul_sign_mode    = in_mode;

    assign w_tag_push = mul_start;
    // A done with no tag outstanding is an orphan; it never bypasses a tag
    // being pushed in the same cycle.
    assign w_tag_pop  = mul_done && !w_tag_empty;
    assign w_res_push = w_tag_pop;
    assign w_res_pop  = out_valid && out_ready;

    sync_fifo #(
        .DW    (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_tag_push),
        .wr_data (in_tag),
        .pop     (w_tag_pop),
        .rd_data (w_tag_head),
        .full    (w_tag_full),
        .empty   (w_tag_empty),
        .count   (w_tag_count)
    );

    sync_fifo #(
        .DW    (RDW),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_res_push),
        .wr_data ({mul_product, w_tag_head}),
        .pop     (w_res_pop),
        .rd_data (w_res_head),
        .full    (w_res_full),
        .empty   (w_res_empty),
        .count   (w_res_count)
    );

    assign out_valid   = !w_res_empty;
    assign out_product = w_res_head[RDW-1:TAG_W];
    assign out_tag     = w_res_head[TAG_W-1:0];
    assign inflight    = w_tag_count;
    assign err_orphan  = r_err_orphan;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_orphan <= 1'b0;
        end else if (mul_done && w_tag_empty) begin
            r_err_orphan <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_res_push && w_res_full && !w_res_pop))
                else $error("booth_mul_dispatcher: result FIFO overflow");
            assert (!(w_tag_push && w_tag_full && !w_tag_pop))
                else $error("booth_mul_dispatcher: tag FIFO overflow");
        end
    end

endmodule

// File: tb/tb_booth_mul_dispatcher.sv
`timescale 1ns/1ps
module tb_booth_mul_dispatcher;
    import booth_pkg::*;

    localparam int WIDTH = 16;
    localparam int TAG_W = 4;
    localparam int DEPTH = 8;
    localparam int LAT   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic [1:0]             in_mode;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_product;
    logic [TAG_W-1:0]       out_tag;
    logic                   mul_start;
    logic [WIDTH-1:0]       mul_multiplicand;
    logic [WIDTH-1:0]       mul_multiplier;
    logic [1:0]             mul_sign_mode;
    logic [2*WIDTH-1:0]     mul_product;
    logic                   mul_done;
    logic                   mul_busy;
    logic [$clog2(DEPTH):0] inflight;
    logic                   err_orphan;

    logic tb_ready;
    logic rand_mode;
    logic rand_bit;
    logic orphan_done;

    assign out_ready = rand_mode ? rand_bit : tb_ready;

    booth_mul_dispatcher #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_mode          (in_mode),
        .in_tag           (in_tag),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .out_tag          (out_tag),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_sign_mode    (mul_sign_mode),
        .mul_product      (mul_product),
        .mul_done         (mul_done),
        .mul_busy         (mul_busy),
        .inflight         (inflight),
        .err_orphan       (err_orphan)
    );

    // Behavioural multi-cycle multiplier: busy for LAT cycles, one done pulse.
    logic               m_busy;
    logic               m_done;
    logic [2*WIDTH-1:0] m_acc;
    logic [2*WIDTH-1:0] m_prod;
    int                 m_cnt;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_prod <= '0;
            m_acc  <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy && mul_start) begin
                m_busy <= 1'b1;
                m_cnt  <= LAT;
                m_acc  <= ref_product(mul_multiplicand, mul_multiplier, mul_sign_mode);
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_prod <= m_acc;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign mul_busy    = m_busy;
    assign mul_done    = m_done | orphan_done;
    assign mul_product = m_prod;

    always @(posedge clk) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: expectations enter on accept, leave on output handshake.
    typedef struct {
        logic [2*WIDTH-1:0] prod;
        logic [TAG_W-1:0]   tag;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sb_q.push_back('{ref_product(in_a, in_b, in_mode), in_tag});
        end
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=tag %0h product %0h required=no output", out_tag, out_product);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_product", out_product, e.prod);
                check("sb_tag", out_tag, e.tag);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [1:0] mode, input logic [TAG_W-1:0] tag,
                        input int budget, output bit ok);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = mode;
        in_tag   = tag;
        ok       = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [1:0]         mode;
        logic [TAG_W-1:0]   tag;
        logic [2*WIDTH-1:0] prod;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int acc;
        int vcount;

        vecs[0] = '{16'd10,   16'd10,   MODE_SS, 4'd3,  32'd100};
        vecs[1] = '{16'h7FFF, 16'h0001, MODE_SS, 4'd5,  32'h0000_7FFF};
        vecs[2] = '{16'h8000, 16'h0001, MODE_SS, 4'd6,  32'hFFFF_8000};
        vecs[3] = '{16'hFFFF, 16'hFFFF, MODE_UU, 4'd7,  32'hFFFE_0001};
        vecs[4] = '{16'hFFFF, 16'hFFFF, MODE_SS, 4'd8,  32'h0000_0001};
        vecs[5] = '{16'hFFFF, 16'h0002, MODE_SU, 4'd9,  32'hFFFF_FFFE};
        vecs[6] = '{16'h0002, 16'hFFFF, MODE_US, 4'd10, 32'hFFFF_FFFE};
        vecs[7] = '{16'h8000, 16'h8000, MODE_UU, 4'd11, 32'h4000_0000};

        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_a        = 16'd1;
        in_b        = 16'd1;
        in_mode     = MODE_SS;
        in_tag      = '0;
        tb_ready    = 1'b0;
        rand_mode   = 1'b0;
        orphan_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_inflight", inflight, 0);
        check("rst_err_orphan", err_orphan, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single op with immediate consumption.
        tb_ready = 1'b1;
        send(16'd10, 16'd10, MODE_SS, 4'd3, 20, ok);
        check("t1_accept", ok, 1);
        wait_out(30, ok);
        check("t1_out_valid", ok, 1);
        check("t1_product", out_product, 32'd100);
        check("t1_tag", out_tag, 4'd3);
        @(posedge clk);
        @(negedge clk);
        check("t1_out_valid_drop", out_valid, 0);
        check("t1_inflight", inflight, 0);

        // Table vectors: buffered while out_ready=0, then drained in order.
        tb_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].tag, 30, ok);
            check("tbl_accept", ok, 1);
        end
        @(posedge clk);
        #1;
        tb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_out(40, ok);
            check("tbl_out_valid", ok, 1);
            check("tbl_product", out_product, vecs[i].prod);
            check("tbl_tag", out_tag, vecs[i].tag);
            @(posedge clk);
            #1;
        end

        // Credit limit: only DEPTH ops admitted while nothing drains.
        tb_ready = 1'b0;
        repeat (10) @(posedge clk);
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            send(16'(i), 16'(i + 1), MODE_SS, 4'(i), 20, ok);
            if (ok) acc++;
        end
        check("t3_accepted", acc, DEPTH);
        @(negedge clk);
        check("t3_in_ready_low", in_ready, 0);
        check("t3_inflight", inflight, 0);
        check("t3_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        tb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_out(20, ok);
            check("t3_drain_valid", ok, 1);
            check("t3_drain_tag", out_tag, 4'(i));
            check("t3_drain_product", out_product, 32'(i * (i + 1)));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t3_in_ready_back", in_ready, 1);
        check("t3_empty", out_valid, 0);

        // Orphan done.
        @(posedge clk);
        #1;
        orphan_done = 1'b1;
        @(posedge clk);
        #1;
        orphan_done = 1'b0;
        @(negedge clk);
        check("t4_err_orphan", err_orphan, 1);
        check("t4_out_valid", out_valid, 0);
        check("t4_inflight", inflight, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t4_err_hold", err_orphan, 1);
        check("t4_out_valid_hold", out_valid, 0);

        // Reset with work outstanding discards everything.
        tb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(16'(i + 2), 16'd3, MODE_SS, 4'(i), 20, ok);
            check("t5_accept", ok, 1);
        end
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_out_valid", out_valid, 0);
        check("t5_inflight", inflight, 0);
        check("t5_err_cleared", err_orphan, 0);
        check("t5_in_ready", in_ready, 1);
        tb_ready = 1'b1;
        vcount = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("t5_no_stale", vcount, 0);

        // Random traffic with random backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            send(16'($urandom), 16'($urandom), MODE_SS, 4'(i), 200, ok);
            if (!ok) check("t6_accept", ok, 1);
        end
        @(posedge clk);
        #1;
        rand_mode = 1'b0;
        tb_ready  = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid && inflight == 0) break;
        end
        check("t6_pending", sb_q.size(), 0);
        check("t6_inflight", inflight, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_err_orphan", err_orphan, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_mul_dispatcher.md
Name: booth_mul_dispatcher

Overview:
Hardware initiator for booth_radix8_multiplier's start/busy/done interface. It accepts tagged multiply requests over valid/ready and issues them to the multiplier whenever busy is low. It matches each done/product to its request tag in order and presents results downstream over valid/ready with full backpressure. Because the multiplier pipeline cannot stall, the dispatcher uses credit-based admission.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH
TAG_W, 4, request tag width
DEPTH, 8, max outstanding ops (issued plus buffered); power of 2, >=2

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&&in_ready at posedge
in_a  in  WIDTH  multiplicand
in_b  in  WIDTH  multiplier
in_mode  in  2  sign mode; bit1 = multiplicand signed, bit0 = multiplier signed
in_tag  in  TAG_W  request tag, returned with result
out_valid  out  1  result valid
out_ready  in  1  downstream ready
out_product  out  2*WIDTH  product
out_tag  out  TAG_W  tag of this product
mul_start  out  1  to multiplier start
mul_multiplicand  out  WIDTH  to multiplier
mul_multiplier  out  WIDTH  to multiplier
mul_sign_mode  out  2  to multiplier
mul_product  in  2*WIDTH  from multiplier
mul_done  in  1  from multiplier, one pulse per result
mul_busy  in  1  from multiplier
inflight  out  $clog2(DEPTH)+1  entries in tag FIFO (issued, not yet done)
err_orphan  out  1  sticky: done seen with no outstanding tag

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low; all state is sampled at posedge clk.
- Reset values: out_valid=0, inflight=0, err_orphan=0, and all FIFO pointers are 0.
  - in_ready=0 and mul_start=0 while rst_n=0.
  - Reset mid-operation discards all outstanding and buffered results. The multiplier shares rst_n.
- Credit rule: outstanding = tag_fifo_count + result_fifo_count.
  - in_ready = !mul_busy && (outstanding < DEPTH).
  - in_ready is combinational from registered state and mul_busy only; it never depends on in_valid.
- Issue: mul_start = in_valid && in_ready.
  - mul_multiplicand, mul_multiplier and mul_sign_mode are driven combinationally from in_a, in_b and in_mode.
  - Values are don't-care when mul_start=0, but must be stable while in_valid is held.
- Acceptance: on accept, in_tag is pushed to the tag FIFO in the same edge.
- Completion: on mul_done with tag FIFO non-empty (registered state before the edge):
  - pop the head tag;
  - write {mul_product, head tag} into the result FIFO at that edge.
  - out_valid rises the cycle after mul_done is sampled; latency is multiplier latency + 1.
- Orphan done: mul_done with tag FIFO empty is dropped and err_orphan is set to 1 until reset. This applies even if an accept occurs in the same cycle; there is no bypass.
- Simultaneous accept and done: push and pop both occur; inflight is unchanged.
- Output: result FIFO is show-ahead. out_valid = !empty; out_product and out_tag come from the head entry.
  - Pop occurs on out_valid && out_ready.
  - Simultaneous push and pop is legal at any fill level, including full.
- Ordering: results leave strictly in acceptance order.
- Overflow: the result FIFO cannot overflow by construction of the credit rule. The implementation asserts this in simulation.
- Products are passed through unmodified; the dispatcher does no arithmetic on data.
- Pointers wrap modulo DEPTH. Each FIFO uses a count register of width $clog2(DEPTH)+1 to distinguish full from empty.

Decomposition:
- Shared package booth_pkg:
  - sign-mode constants MODE_UU=2'b00, MODE_US=2'b01, MODE_SU=2'b10, MODE_SS=2'b11;
  - a helper function for the reference product model, used by the benches.
- One sub-module, sync_fifo: parameters DW and DEPTH, show-ahead, push/pop/full/empty/count, synchronous active-low reset.
  - Instanced twice: tag FIFO (DW=TAG_W) and result FIFO (DW=2*WIDTH+TAG_W).

Test Plan:
1. 10*10, mode 11, tag 3, out_ready=1 -> one out_valid pulse: product 100, tag 3; inflight returns to 0.
2. 32767*1, then -32768*1 (mode 11), then 0xFFFF*0xFFFF (mode 00), back-to-back -> products 32767, -32768, 0xFFFE0001, in order.
3. out_ready=0, 12 requests offered -> exactly 8 accepted, then in_ready=0. Raising out_ready drains tags 0..7 in order, after which in_ready returns high.
4. Force mul_done with nothing outstanding -> err_orphan=1, out_valid stays 0, err_orphan holds until rst_n=0.
5. Accept 3 ops, assert rst_n=0 for 1 cycle before any done -> out_valid=0, inflight=0; no stale result appears afterwards.
6. 5000 random ops, mode 11, random out_ready (50%) -> all products and tags match the model, in order, with zero errors and nothing pending at the end.
